date_set_controller: RTL and testbench
======================================

# date_set_controller

Sequencing controller for the calendar datapath on the DE10-Lite display design. Owns the month/day registers, advances them on the divided-clock tick while running, and lets the user set month and day with two pushbuttons through a three-state mode machine. Outputs drive the seven-segment decoders directly (month digit, day tens, day units) plus a blink flag for the field being edited.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable clocks required before a key level is accepted.
- BLINK_TICKS, 2: ticks per blink half-period in set modes.

Ports:
- clock  input  1  system clock (ADC_CLK_10 domain); one clock.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  one-cycle enable from the clock divider; advances the date in RUN.
- key_mode_n  input  1  raw pushbutton, active-low, asynchronous.
- key_inc_n  input  1  raw pushbutton, active-low, asynchronous.
- month  output  4  binary month, 1..12.
- day10  output  2  BCD day tens, 0..3.
- day1  output  4  BCD day units, 0..9.
- mode  output  2  0=RUN, 1=SET_MONTH, 2=SET_DAY.
- blink  output  1  blank request for the edited field.
- year_tick  output  1  one-cycle pulse on Dec 31 -> Jan 1 rollover.

## Operation
- Key path per button: 2-FF synchronizer, then debounce counter. Accepted level changes only after DEBOUNCE_CYCLES consecutive equal samples. Press event = accepted level transitions 1->0; exactly one-cycle pulse per physical press. Releases generate nothing.
- FSM: RUN -mode press-> SET_MONTH -mode press-> SET_DAY -mode press-> RUN. Encoding 3 is unreachable and recovers to RUN on the next clock.
- RUN: on tick, day += 1. If day == month length, day = 01 and month += 1. If month was 12, month = 1 and year_tick pulses. inc presses are ignored.
- SET_MONTH: inc press -> month += 1, 12 wraps to 1. Day clamps to the new month length in the same update (e.g., 31 Jan -> 28 Feb). Ticks are ignored, so the date is frozen.
- SET_DAY: inc press -> day += 1, wrapping from month length to 01. Month is unchanged. Ticks are ignored.
- Month lengths: 31 for 1,3,5,7,8,10,12. 30 for 4,6,9,11. 28 for 2.
- Day is held internally as BCD: day1 carries into day10 at 9 -> 0. The value 00 is never produced.
- blink: 0 in RUN. In set modes it toggles every BLINK_TICKS ticks, and is forced to 1 on entry to each set mode.

## Timing
- Reset values: month=1, day10=0, day1=1, mode=0, blink=0, year_tick=0. Debounce levels are 1 (released) and counters are 0.
- Key latency: press pulse occurs 2 + DEBOUNCE_CYCLES clocks after the raw edge, if the raw level is stable for that long.
- Register updates land on the clock edge where the tick or press pulse is high. Outputs are registered and visible the next cycle.
- Simultaneous mode press and inc press: mode wins and inc is dropped.
- Simultaneous tick and mode press in RUN: date advances and state moves to SET_MONTH on the same edge.
- tick held high for multiple cycles: each high cycle counts as one advance. The divider guarantees single-cycle pulses.
- Reset asserted mid-debounce or mid-edit: all state returns to reset values immediately. Any partially debounced press is discarded.

## Configuration
- LEAP_YEAR_EN:
  - Defined: adds a 2-bit year counter (reset 0) that increments on each year_tick. February length is 29 when year == 0, otherwise 28. Clamping and SET_DAY wrapping use that length.
  - Undefined: no year counter, and February is always 28. year_tick is still generated.

## Test plan
Bench overrides: DEBOUNCE_CYCLES=4, BLINK_TICKS=2.
- Reset, then 30 ticks in RUN -> month=1, day=31. One more tick -> month=2, day=01.
- Preload Dec 31 via SET_MONTH/SET_DAY presses, return to RUN, one tick -> month=1, day=01, year_tick high for exactly 1 cycle.
- Raw key_inc_n toggles every 2 cycles for 20 cycles, then held low 10 cycles in SET_MONTH -> exactly one increment, month 1->2.
- In SET_DAY set Jan 31, mode x2 to SET_MONTH, inc -> month=2, day=28. Also confirm ticks during set modes leave the date unchanged.
- Mode and inc pulses arrive on the same cycle in SET_MONTH -> mode=2 and month unchanged. Reset asserted mid-edit -> month=1, day=01, mode=0 immediately.
- LEAP_YEAR_EN defined, from reset: Feb 28 + tick -> Feb 29, next tick -> Mar 01. After one year_tick (year=1): Feb 28 + tick -> Mar 01.

Source files
------------

// File: rtl/date_set_controller.sv
// date_set_controller
//   Month/day sequencer for the seven-segment calendar display. Advances the
//   date on the divider tick while running, and lets the user set month and
//   day with two pushbuttons through a RUN -> SET_MONTH -> SET_DAY mode loop.
//
// Ports
//   clock       system clock
//   reset       asynchronous, active-high reset
//   tick        one-cycle advance enable from the clock divider
//   key_mode_n  raw mode pushbutton, active-low, asynchronous
//   key_inc_n   raw increment pushbutton, active-low, asynchronous
//   month       binary month 1..12
//   day10       BCD day tens 0..3
//   day1        BCD day units 0..9
//   mode        0=RUN, 1=SET_MONTH, 2=SET_DAY
//   blink       blank request for the field being edited
//   year_tick   one-cycle pulse on the Dec 31 -> Jan 1 rollover
//
// Build option
//   LEAP_YEAR_EN  adds a 2-bit year counter; February has 29 days when the
//                 counter is 0. Without it February is always 28 days.
module date_set_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BLINK_TICKS     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  output logic [3:0] month,
  output logic [1:0] day10,
  output logic [3:0] day1,
  output logic [1:0] mode,
  output logic       blink,
  output logic       year_tick
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_MON = 2'd1;
  localparam logic [1:0] S_DAY = 2'd2;

  // Month length as a two-digit BCD value, so it compares directly against
  // the BCD day register.
  function automatic logic [5:0] month_len_bcd(input logic [3:0] m, input logic leap);
    case (m)
      4'd2:                       month_len_bcd = leap ? 6'h29 : 6'h28;
      4'd4, 4'd6, 4'd9, 4'd11:    month_len_bcd = 6'h30;
      default:                    month_len_bcd = 6'h31;
    endcase
  endfunction

  function automatic logic [5:0] bcd_inc(input logic [5:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[5:4] + 2'd1, 4'd0};
    else                bcd_inc = {v[5:4], v[3:0] + 4'd1};
  endfunction

  // ---------------------------------------------------------------------
  // Key path: index 0 = mode, index 1 = inc
  // ---------------------------------------------------------------------
  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync2_q, level_q, press_q;
  logic [CW-1:0] cnt_q [2];

  assign raw = {key_inc_n, key_mode_n};

  // The accepted level only moves after DEBOUNCE_CYCLES consecutive samples
  // disagreeing with it; any agreeing sample restarts the count. A press is
  // the accepted 1->0 transition, registered so it lasts exactly one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      level_q <= 2'b11;
      press_q <= 2'b00;
      for (int k = 0; k < 2; k++) cnt_q[k] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int k = 0; k < 2; k++) begin
        press_q[k] <= 1'b0;
        if (sync2_q[k] == level_q[k]) begin
          cnt_q[k] <= '0;
        end else if (cnt_q[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_q[k]   <= '0;
          level_q[k] <= sync2_q[k];
          press_q[k] <= level_q[k];
        end else begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  logic press_mode, press_inc;
  assign press_mode = press_q[0];
  assign press_inc  = press_q[1];

  // ---------------------------------------------------------------------
  // Mode machine and date registers
  // ---------------------------------------------------------------------
  logic [1:0]    state_q, state_d;
  logic [3:0]    month_q, month_d;
  logic [5:0]    day_q, day_d;          // {tens, units} BCD
  logic          blink_q, blink_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          ytick_q, ytick_d;
  logic          leap;
  logic [5:0]    len_cur, len_new;
  logic [3:0]    month_inc;

`ifdef LEAP_YEAR_EN
  logic [1:0] year_q, year_d;
  assign leap = (year_q == 2'd0);
`else
  assign leap = 1'b0;
`endif

  assign len_cur   = month_len_bcd(month_q, leap);
  assign month_inc = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
  assign len_new   = month_len_bcd(month_inc, leap);

  always_comb begin
    state_d = state_q;
    month_d = month_q;
    day_d   = day_q;
    blink_d = blink_q;
    bcnt_d  = bcnt_q;
    ytick_d = 1'b0;

    case (state_q)
      S_RUN: begin
        if (tick) begin
          if (day_q == len_cur) begin
            day_d   = 6'h01;
            month_d = month_inc;
            ytick_d = (month_q == 4'd12);
          end else begin
            day_d = bcd_inc(day_q);
          end
        end
        blink_d = 1'b0;
        if (press_mode) begin
          state_d = S_MON;
          blink_d = 1'b1;
          bcnt_d  = '0;
        end
      end
      S_MON, S_DAY: begin
        if (press_mode) begin
          // Mode wins over a coincident inc press.
          state_d = (state_q == S_MON) ? S_DAY : S_RUN;
          blink_d = (state_q == S_MON);
          bcnt_d  = '0;
        end else begin
          if (press_inc) begin
            if (state_q == S_MON) begin
              month_d = month_inc;
              if (day_q > len_new) day_d = len_new;
            end else begin
              day_d = (day_q == len_cur) ? 6'h01 : bcd_inc(day_q);
            end
          end
          if (tick) begin
            if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
              bcnt_d  = '0;
              blink_d = ~blink_q;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = S_RUN;
        blink_d = 1'b0;
        bcnt_d  = '0;
      end
    endcase
  end

`ifdef LEAP_YEAR_EN
  always_comb year_d = year_q + {1'b0, ytick_d};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) year_q <= 2'd0;
    else       year_q <= year_d;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      month_q <= 4'd1;
      day_q   <= 6'h01;
      blink_q <= 1'b0;
      bcnt_q  <= '0;
      ytick_q <= 1'b0;
    end else begin
      state_q <= state_d;
      month_q <= month_d;
      day_q   <= day_d;
      blink_q <= blink_d;
      bcnt_q  <= bcnt_d;
      ytick_q <= ytick_d;
    end
  end

  assign month     = month_q;
  assign day10     = day_q[5:4];
  assign day1      = day_q[3:0];
  assign mode      = state_q;
  assign blink     = blink_q;
  assign year_tick = ytick_q;

endmodule

// File: tb/tb_date_set_controller.sv
module tb_date_set_controller;

  localparam int DEB = 4;
  localparam int BT  = 2;

  logic       clock = 1'b0;
  logic       reset, tick, key_mode_n, key_inc_n;
  logic [3:0] month;
  logic [1:0] day10;
  logic [3:0] day1;
  logic [1:0] mode;
  logic       blink, year_tick;

  date_set_controller #(.DEBOUNCE_CYCLES(DEB), .BLINK_TICKS(BT)) dut (
    .clock(clock), .reset(reset), .tick(tick),
    .key_mode_n(key_mode_n), .key_inc_n(key_inc_n),
    .month(month), .day10(day10), .day1(day1),
    .mode(mode), .blink(blink), .year_tick(year_tick)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] m;
    logic [1:0] d10;
    logic [3:0] d1;
    logic [1:0] md;
    logic       bl;
  } snap_t;

  snap_t expq[$];
  snap_t e_s, a_s;
  int total = 0;
  int bad   = 0;
  int yt_seen = 0;

  // Reference model: plain calendar arithmetic on integers.
  int mm, md, ms, mb, mbc, my, myt;

  function automatic int mlen(input int m, input int y);
    if (m == 2) begin
`ifdef LEAP_YEAR_EN
      return (y == 0) ? 29 : 28;
`else
      return 28;
`endif
    end
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic m_reset();
    mm = 1; md = 1; ms = 0; mb = 0; mbc = 0; my = 0;
  endtask

  task automatic m_tick();
    if (ms == 0) begin
      md++;
      if (md > mlen(mm, my)) begin
        md = 1;
        mm++;
        if (mm > 12) begin
          mm = 1;
          my = (my + 1) % 4;
          myt++;
        end
      end
    end else begin
      mbc++;
      if (mbc == BT) begin
        mb  = 1 - mb;
        mbc = 0;
      end
    end
  endtask

  task automatic m_mode();
    ms  = (ms + 1) % 3;
    mb  = (ms == 0) ? 0 : 1;
    mbc = 0;
  endtask

  task automatic m_inc();
    if (ms == 1) begin
      mm = (mm % 12) + 1;
      if (md > mlen(mm, my)) md = mlen(mm, my);
    end else if (ms == 2) begin
      md = (md >= mlen(mm, my)) ? 1 : md + 1;
    end
  endtask

  task automatic push_exp();
    snap_t s;
    s.m   = 4'(mm);
    s.d10 = 2'(md / 10);
    s.d1  = 4'(md % 10);
    s.md  = 2'(ms);
    s.bl  = 1'(mb);
    expq.push_back(s);
  endtask

  // Monitor: compares each queued expectation against the outputs on the
  // falling edge, away from the active edge.
  always @(negedge clock) begin
    while (expq.size() > 0) begin
      e_s = expq.pop_front();
      a_s = {month, day10, day1, mode, blink};
      total++;
      if (a_s !== e_s) begin
        bad++;
        $display("FAIL state: got m=%0d d=%0d%0d mode=%0d blink=%0d, want m=%0d d=%0d%0d mode=%0d blink=%0d",
                 a_s.m, a_s.d10, a_s.d1, a_s.md, a_s.bl, e_s.m, e_s.d10, e_s.d1, e_s.md, e_s.bl);
      end
    end
  end

  always @(negedge clock) if (year_tick === 1'b1) yt_seen++;

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic do_tick();
    @(negedge clock);
    tick = 1'b1;
    @(posedge clock);
    #1 tick = 1'b0;
    m_tick();
    push_exp();
  endtask

  task automatic release_keys();
    @(negedge clock);
    key_mode_n = 1'b1;
    key_inc_n  = 1'b1;
    repeat (DEB + 4) @(posedge clock);
  endtask

  // Press pulse is registered 2+DEB edges after the raw edge; the state
  // update lands on the following edge.
  task automatic press(input bit mode_k, input bit inc_k);
    @(negedge clock);
    if (mode_k) key_mode_n = 1'b0;
    if (inc_k)  key_inc_n  = 1'b0;
    repeat (DEB + 3) @(posedge clock);
    #1;
    if (mode_k)     m_mode();
    else if (inc_k) m_inc();
    push_exp();
    release_keys();
  endtask

  task automatic press_mode_tick();
    @(negedge clock);
    key_mode_n = 1'b0;
    repeat (DEB + 2) @(posedge clock);
    #1 tick = 1'b1;
    @(posedge clock);
    #1 tick = 1'b0;
    m_tick();
    m_mode();
    push_exp();
    release_keys();
  endtask

  task automatic set_date(input int tm, input int td);
    press(1, 0);
    while (mm != tm) press(0, 1);
    press(1, 0);
    while (md != td) press(0, 1);
    press(1, 0);
  endtask

  initial begin
    int r;
    reset = 1'b1; tick = 1'b0; key_mode_n = 1'b1; key_inc_n = 1'b1;
    myt = 0;
    m_reset();
    repeat (3) @(posedge clock);
    #1 push_exp();
    @(negedge clock);
    reset = 1'b0;

    // Walk through January into February.
    repeat (30) do_tick();
    do_tick();

    // Dec 31 -> Jan 1 rollover.
    set_date(12, 31);
    do_tick();

    // Bouncing inc key in SET_MONTH yields exactly one increment.
    press(1, 0);
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      key_inc_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) @(negedge clock);
    end
    key_inc_n = 1'b0;
    repeat (10) @(negedge clock);
    m_inc();
    push_exp();
    release_keys();

    // Jan 31 in SET_DAY, back around to SET_MONTH, inc clamps to Feb 28.
    while (mm != 1) press(0, 1);
    press(1, 0);
    while (md != 31) press(0, 1);
    repeat (3) do_tick();
    press(1, 0);
    press(1, 0);
    press(0, 1);
    repeat (3) do_tick();

    // Coincident mode and inc: mode wins.
    press(1, 1);

    // Reset during a partially debounced press while editing.
    @(negedge clock);
    key_inc_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    key_inc_n = 1'b1;
    m_reset();
    push_exp();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (DEB + 4) @(posedge clock);
    #1 push_exp();

    // February length depends on the year counter when leap support is built.
    set_date(2, 28);
    do_tick();
    do_tick();
    set_date(12, 31);
    do_tick();
    set_date(2, 28);
    do_tick();

    // Tick coincident with mode press in RUN.
    press_mode_tick();
    press(1, 0);
    press(1, 0);

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 4);
      case (r)
        0, 1: do_tick();
        2:    press(1, 0);
        3:    press(0, 1);
        default: begin
          if (ms == 0) press_mode_tick();
          else         press(1, 1);
        end
      endcase
    end

    repeat (4) @(negedge clock);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want 0", expq.size());
    end
    total++;
    if (yt_seen != myt) begin
      bad++;
      $display("FAIL year_tick: cycles high=%0d want %0d", yt_seen, myt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
